// File: rtl/aes128_iter_ctrl.sv
// aes128_iter_ctrl -- iterative AES-128 encryption controller.
//
// Accepts one plaintext/key pair, applies the initial AddRoundKey and then
// runs one AES round per clock on a shared round datapath. Ten rounds are
// run, and the last round skips MixColumns. Round keys are expanded on the
// fly from the previous round key.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready high only in IDLE)
//   plain, key [0:127]  plaintext / cipher key, byte 0 in bits 0..7
//   out_valid/out_ready result handshake (out_ready used only when stalling)
//   cipher [0:127]      ciphertext, driven from the state register
//   busy                high while a block is in RUN or DONE
//   round [3:0]         current round index, 0 in IDLE, 1..10 in RUN, 10 in DONE
//
// Build option: define AES128_ITER_STALL_EN so that DONE holds the result until
// out_ready. Without it, DONE lasts one cycle and out_ready has no effect.
module aes128_iter_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] plain,
  input  logic [0:127] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] cipher,
  output logic         busy,
  output logic [3:0]   round
);

  // Forward S-box, entry x at bits [8x +: 8]
  localparam logic [0:2047] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One MixColumns column; byte 0 of the column sits in the top byte
  function automatic logic [31:0] mixcol(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  state_e       r_fsm, w_fsm_nxt;
  logic [127:0] r_state, r_rkey;   // byte i at bits [127-8i -: 8]
  logic [3:0]   r_rnd;
  logic [7:0]   r_rcon;

  logic [127:0] w_sr, w_mc, w_nk, w_rnd_out;
  logic [31:0]  w_t;
  logic         w_last, w_done_exit;

  assign w_last = (r_rnd == 4'd10);

`ifdef AES128_ITER_STALL_EN
  assign w_done_exit = out_ready;
`else
  // DONE always lasts one cycle; out_ready is read here only so it is not a dangling input
  assign w_done_exit = out_ready | 1'b1;
`endif

  // Round datapath: SubBytes+ShiftRows, MixColumns, key expansion
  always_comb begin
    w_sr = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[127-8*(4*c+r) -: 8] = sbox(r_state[127-8*(4*((c+r)%4)+r) -: 8]);

    w_mc = '0;
    for (int c = 0; c < 4; c++)
      w_mc[127-32*c -: 32] = mixcol(w_sr[127-32*c -: 32]);

    // RotWord + SubWord of w3, rcon folded into the leading byte
    w_t = {sbox(r_rkey[23:16]) ^ r_rcon, sbox(r_rkey[15:8]),
           sbox(r_rkey[7:0]), sbox(r_rkey[31:24])};
    w_nk[127:96] = r_rkey[127:96] ^ w_t;
    w_nk[95:64]  = r_rkey[95:64] ^ w_nk[127:96];
    w_nk[63:32]  = r_rkey[63:32] ^ w_nk[95:64];
    w_nk[31:0]   = r_rkey[31:0]  ^ w_nk[63:32];

    w_rnd_out = (w_last ? w_sr : w_mc) ^ w_nk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_fsm_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_fsm_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_done_exit) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_rkey  <= '0;
      r_rnd   <= 4'd0;
      r_rcon  <= 8'h01;
    end else begin
      case (r_fsm)
        S_IDLE: if (in_valid) begin
          r_state <= plain ^ key;
          r_rkey  <= key;
          r_rnd   <= 4'd1;
          r_rcon  <= 8'h01;
        end
        S_RUN: begin
          r_state <= w_rnd_out;
          r_rkey  <= w_nk;
          r_rcon  <= xt(r_rcon);       // 0x80 -> 0x1b through the reduction
          if (!w_last) r_rnd <= r_rnd + 4'd1;  // round reads 10 through DONE
        end
        S_DONE: if (w_done_exit) r_rnd <= 4'd0;
        default: ;
      endcase
    end
  end

  assign cipher = r_state;
  assign round  = r_rnd;

endmodule
